hyperbus_target: RTL and testbench
==================================

# hyperbus_target

Synthesizable HyperBus device-side responder: the far end of the `hyperbus` controller PHY pins, emulating a single HyperRAM chip with a small flop-array memory and one configuration register. Used for on-chip/FPGA loopback of the controller and as a deterministic bench target. Inputs are synchronous to `clk_i`, and `clk_i` runs at ≥4× the HyperBus CK rate. CK edges are detected by oversampling.

## Interface
- `AddrWidth`, default 8: memory depth is 2**AddrWidth 16-bit words.
- `Latency`, default 6: initial access latency in CK cycles, always applied doubled (2× latency).
- `Cr0Default`, default 16'h8F1F: reset value of CR0.
- `Id0Value`, default 16'h0C81: value returned for register-space reads at word address 0.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; one clock, synchronous, active-low.
- `hyper_cs_ni` in 1: chip select, active low.
- `hyper_ck_i` in 1: HyperBus clock, sampled as data.
- `hyper_reset_ni` in 1: device reset, active low; same effect as `rst_ni`.
- `hyper_dq_i` in 8: DQ from controller.
- `hyper_dq_o` out 8: DQ to controller.
- `hyper_dq_oe_o` out 1: DQ output enable.
- `hyper_rwds_i` in 1: write byte mask from controller (1 = byte masked).
- `hyper_rwds_o` out 1: latency indicator / read strobe.
- `hyper_rwds_oe_o` out 1: RWDS output enable.
- `busy_o` out 1: transaction in progress.
- `abort_o` out 1: one-cycle pulse when CS rises before a transaction completes its CA phase.

## Operation
- **Edge detect:** `ck_q` holds the previous `hyper_ck_i` sample. An edge occurs when `hyper_ck_i != ck_q` and `hyper_cs_ni == 0`. Edges are numbered from 0 after CS falls.
- **CA decode:** edges 0–5 shift `hyper_dq_i` MSB-first into a 48-bit CA.
  - CA[47]: 1 = read.
  - CA[46]: 1 = register space.
  - CA[45]: burst type. It is ignored; all bursts are linear.
  - Word address = {CA[44:16], CA[2:0]} truncated to AddrWidth. Higher bits alias.
- **States:** IDLE, CA, LAT, WDATA, RDATA, REGW, DONE.
  - IDLE→CA: CS falls.
  - CA→REGW: after edge 5, register write (zero latency).
  - CA→RDATA: after edge 5, register read, after LAT.
  - CA→LAT: after edge 5, memory access.
  - LAT→WDATA or RDATA: after 4·Latency−4 latency edges, so the first data edge is 4·Latency+2.
  - Any state→IDLE: CS high, checked every cycle.
- **Data bytes:** each word is two edges, upper byte [15:8] first, then [7:0].
- **WDATA:**
  - A byte is written only if `hyper_rwds_i` is 0 at its edge.
  - The word is committed on its second edge, then the address increments modulo 2**AddrWidth.
- **RDATA:** the byte for each data edge is driven on `hyper_dq_o`. The address increments after the second byte.
- **REGW:** the first full word sets CR0. Later words are ignored.
- **Register read:** word address 0 returns Id0Value; any other address returns CR0.
- **RWDS drive:**
  - `hyper_rwds_oe_o` = 1, `hyper_rwds_o` = 1 from the cycle after CS falls through the cycle after edge 5.
  - Reads: RWDS stays driven low in LAT. In RDATA it toggles with each byte; first byte `hyper_rwds_o` = 1.
  - Writes: RWDS is released after CA.
- **CS rise:**
  - Odd data byte count: the half word is discarded; all earlier full words stay committed.
  - CS rise with fewer than 6 CA edges pulses `abort_o`.
- **Reset:** memory content is not reset. State→IDLE, CR0 = Cr0Default.

## Timing
- **Output reset values:** `hyper_dq_o`=0, `hyper_dq_oe_o`=0, `hyper_rwds_o`=0, `hyper_rwds_oe_o`=0, `busy_o`=0, `abort_o`=0.
- **Output latency:** all outputs are registered. An edge detected in cycle t produces its response in cycle t+1.
- **Read bytes:** for data edge k detected at t, `hyper_dq_o` = byte k and `hyper_rwds_o` toggles at t+1. `hyper_dq_oe_o` rises at t+1 of the first data edge.
- **CS release:** when CS is sampled high at t, `hyper_dq_oe_o`, `hyper_rwds_oe_o` and `busy_o` are 0 at t+1.
- **Write commit:** a word committed at t is readable by a transaction whose first data edge comes at t+1 or later.
- **busy_o:** 1 from the cycle after CS falls until the cycle after CS rises.
- **CS and CK together:** if CS rises in the same sample as a CK change, the edge is ignored.

## Structure
- **Package `hyperbus_target_pkg`:**
  - `state_e` enum.
  - `ca_t` packed struct (rw, as, burst, row, col).
  - Constants: CA edge count 6, RWDS latency level.
- **Sub-module `hyperbus_target_mem`:**
  - 2**AddrWidth×16 flop array.
  - Asynchronous read.
  - Synchronous write with 2-bit byte enable.

## Test plan
- **Mem write then read:** write 4 words 1111/2222/3333/4444 at address 0x10 with no masking. Reading 4 words at 0x10 returns the bytes 11 11 22 22 33 33 44 44, and the first data byte arrives at edge 26.
- **Masked write:** write 16'hABCD to address 5 with RWDS=1 on the lower byte, over a prior value of 0000. Read-back gives AB00.
- **Address wrap:** a 3-word write at address 0xFF with AddrWidth=8 lands at 0xFF, 0x00, 0x01.
- **Register space:**
  - Reading word address 0 returns 0C81.
  - A zero-latency write of 8F17 followed by a read of word address 0x800 returns 8F17.
  - After `hyper_reset_ni` low for one cycle, the same read returns 8F1F.
- **Aborts:**
  - CS rise after 3 CA edges pulses `abort_o` for one cycle and returns to IDLE.
  - CS rise after 3 write data bytes commits word 0 only.
- **Reset:** `rst_ni` low during RDATA drops `hyper_dq_oe_o` and `hyper_rwds_oe_o` to 0 in the next cycle. A new transaction after reset decodes its CA correctly.

Source files
------------

// File: rtl/hyperbus_target_pkg.sv
// rtl/hyperbus_target_pkg.sv - shared types and constants for the HyperBus target
// Contents: transaction state enum, command/address word layout,
// CA edge count, RWDS level driven during read latency, address helper.
package hyperbus_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WDATA,
        ST_RDATA,
        ST_REGW,
        ST_DONE
    } state_e;

    // 48-bit command/address word as shifted in MSB-first over edges 0..5.
    typedef struct packed {
        logic        rw;     // 1 = read
        logic        as;     // 1 = register space
        logic        burst;  // ignored, bursts are always linear
        logic [28:0] row;    // upper word address
        logic [12:0] rsvd;
        logic [2:0]  col;    // lower word address
    } ca_t;

    localparam int unsigned CA_EDGES       = 6;
    localparam logic        RWDS_LAT_LEVEL = 1'b0;

    function automatic logic [31:0] ca_word_addr(input ca_t ca);
        return {ca.row, ca.col};
    endfunction

endpackage

// File: rtl/hyperbus_target_mem.sv
// rtl/hyperbus_target_mem.sv - word memory with asynchronous read and byte-enabled write
// Ports: clk_i; addr_i shared word address; we_i/be_i/wdata_i write port
// (be_i[1] = bits 15:8); rdata_o combinational read of addr_i.
module hyperbus_target_mem #(
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [1:0]           be_i,
    input  logic [15:0]          wdata_i,
    output logic [15:0]          rdata_o
);

    // Contents are deliberately not reset.
    logic [15:0] mem_q [2**AddrWidth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
            if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hyperbus_target.sv
// rtl/hyperbus_target.sv - HyperRAM-style device responder with oversampled CK
// Ports: clk_i/rst_ni system clock and sync active-low reset; hyper_* pins
// of the HyperBus device side (cs, ck, reset, dq, rwds with output enables);
// busy_o transaction in progress; abort_o one-cycle pulse on early CS release.
module hyperbus_target
    import hyperbus_target_pkg::*;
#(
    parameter int unsigned AddrWidth  = 8,
    parameter int unsigned Latency    = 6,
    parameter logic [15:0] Cr0Default = 16'h8F1F,
    parameter logic [15:0] Id0Value   = 16'h0C81
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hyper_cs_ni,
    input  logic       hyper_ck_i,
    input  logic       hyper_reset_ni,
    input  logic [7:0] hyper_dq_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o,
    input  logic       hyper_rwds_i,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o,
    output logic       busy_o,
    output logic       abort_o
);

    localparam logic [7:0] CA_LAST  = 8'(CA_EDGES - 1);
    localparam logic [7:0] LAT_LAST = 8'(4 * Latency - 5);

    state_e      state_q, state_d, cur;
    logic        ck_q;
    logic [7:0]  cnt_q, cnt_d, cnt_cur;
    logic [39:0] ca_sr_q, ca_sr_d;
    logic        rw_q, rw_d, as_q, as_d;
    logic [31:0] addr_q, addr_d;
    logic        odd_q, odd_d;
    logic [7:0]  hi_q, hi_d;
    logic        hi_mask_q, hi_mask_d;
    logic [15:0] cr0_q, cr0_d;
    logic [7:0]  dq_q, dq_d;
    logic        dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d;
    logic        busy_q, busy_d, abort_q, abort_d;

    logic        rst_n, edge_det, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata, rd_word;
    ca_t         ca_next;
    logic        ca_unused;

    assign rst_n    = rst_ni & hyper_reset_ni;
    // A CK change in the same sample as CS rising is not an edge.
    assign edge_det = (hyper_ck_i != ck_q) && !hyper_cs_ni;
    assign ca_next  = ca_t'({ca_sr_q, hyper_dq_i});
    assign ca_unused = ^{ca_next.burst, ca_next.rsvd};

    hyperbus_target_mem #(.AddrWidth(AddrWidth)) u_mem (
        .clk_i   (clk_i),
        .addr_i  (addr_q[AddrWidth-1:0]),
        .we_i    (mem_we & rst_n),
        .be_i    (mem_be),
        .wdata_i ({hi_q, hyper_dq_i}),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ca_sr_d   = ca_sr_q;
        rw_d      = rw_q;
        as_d      = as_q;
        addr_d    = addr_q;
        odd_d     = odd_q;
        hi_d      = hi_q;
        hi_mask_d = hi_mask_q;
        cr0_d     = cr0_q;
        dq_d      = dq_q;
        dq_oe_d   = dq_oe_q;
        rwds_d    = rwds_q;
        rwds_oe_d = rwds_oe_q;
        busy_d    = 1'b0;
        abort_d   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        cur       = state_q;
        cnt_cur   = cnt_q;
        // Register space: full word address 0 is the ID, everything else CR0.
        rd_word   = as_q ? ((addr_q == '0) ? Id0Value : cr0_q) : mem_rdata;

        if (hyper_cs_ni) begin
            abort_d   = (state_q == ST_CA);
            state_d   = ST_IDLE;
            dq_d      = '0;
            dq_oe_d   = 1'b0;
            rwds_d    = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            busy_d = 1'b1;
            // CS just fell: an edge in this same sample is CA edge 0.
            if (state_q == ST_IDLE) begin
                cur       = ST_CA;
                cnt_cur   = '0;
                cnt_d     = '0;
                state_d   = ST_CA;
                dq_d      = '0;
                dq_oe_d   = 1'b0;
                rwds_d    = 1'b1;
                rwds_oe_d = 1'b1;
            end

            // RWDS level once CA is over: reads hold it low, writes release it.
            case (cur)
                ST_LAT: begin
                    rwds_oe_d = rw_q;
                    rwds_d    = rw_q ? RWDS_LAT_LEVEL : 1'b0;
                end
                ST_WDATA, ST_REGW, ST_DONE: begin
                    rwds_oe_d = 1'b0;
                    rwds_d    = 1'b0;
                end
                default: ;
            endcase

            if (edge_det) begin
                case (cur)
                    ST_CA: begin
                        ca_sr_d = ca_next[39:0];
                        cnt_d   = cnt_cur + 8'd1;
                        if (cnt_cur == CA_LAST) begin
                            rw_d    = ca_next.rw;
                            as_d    = ca_next.as;
                            addr_d  = ca_word_addr(ca_next);
                            cnt_d   = '0;
                            odd_d   = 1'b0;
                            state_d = (!ca_next.rw && ca_next.as) ? ST_REGW : ST_LAT;
                        end
                    end
                    ST_LAT: begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LAT_LAST) state_d = rw_q ? ST_RDATA : ST_WDATA;
                    end
                    ST_WDATA: begin
                        odd_d = ~odd_q;
                        if (!odd_q) begin
                            hi_d      = hyper_dq_i;
                            hi_mask_d = hyper_rwds_i;
                        end else begin
                            mem_we = 1'b1;
                            mem_be = {~hi_mask_q, ~hyper_rwds_i};
                            addr_d = addr_q + 32'd1;
                        end
                    end
                    ST_RDATA: begin
                        dq_d      = odd_q ? rd_word[7:0] : rd_word[15:8];
                        dq_oe_d   = 1'b1;
                        rwds_d    = ~odd_q;
                        rwds_oe_d = 1'b1;
                        odd_d     = ~odd_q;
                        if (odd_q) addr_d = addr_q + 32'd1;
                    end
                    ST_REGW: begin
                        odd_d = ~odd_q;
                        if (!odd_q) begin
                            hi_d = hyper_dq_i;
                        end else begin
                            cr0_d   = {hi_q, hyper_dq_i};
                            state_d = ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ck_q      <= 1'b0;
            cnt_q     <= '0;
            ca_sr_q   <= '0;
            rw_q      <= 1'b0;
            as_q      <= 1'b0;
            addr_q    <= '0;
            odd_q     <= 1'b0;
            hi_q      <= '0;
            hi_mask_q <= 1'b0;
            cr0_q     <= Cr0Default;
            dq_q      <= '0;
            dq_oe_q   <= 1'b0;
            rwds_q    <= 1'b0;
            rwds_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ck_q      <= hyper_ck_i;
            cnt_q     <= cnt_d;
            ca_sr_q   <= ca_sr_d;
            rw_q      <= rw_d;
            as_q      <= as_d;
            addr_q    <= addr_d;
            odd_q     <= odd_d;
            hi_q      <= hi_d;
            hi_mask_q <= hi_mask_d;
            cr0_q     <= cr0_d;
            dq_q      <= dq_d;
            dq_oe_q   <= dq_oe_d;
            rwds_q    <= rwds_d;
            rwds_oe_q <= rwds_oe_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
        end
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;
    assign busy_o          = busy_q;
    assign abort_o         = abort_q;

endmodule

// File: tb/tb_hyperbus_target.sv
// tb/tb_hyperbus_target.sv - self-checking bench for hyperbus_target
module tb_hyperbus_target;

    localparam int          LAT     = 6;
    localparam logic [15:0] ID0     = 16'h0C81;
    localparam logic [15:0] CR0_DEF = 16'h8F1F;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       hyper_cs_ni = 1'b1;
    logic       hyper_ck_i = 1'b0;
    logic       hyper_reset_ni = 1'b1;
    logic [7:0] hyper_dq_i = 8'h00;
    logic       hyper_rwds_i = 1'b0;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o, busy_o, abort_o;

    always #5 clk = ~clk;

    hyperbus_target dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .hyper_cs_ni     (hyper_cs_ni),
        .hyper_ck_i      (hyper_ck_i),
        .hyper_reset_ni  (hyper_reset_ni),
        .hyper_dq_i      (hyper_dq_i),
        .hyper_dq_o      (hyper_dq_o),
        .hyper_dq_oe_o   (hyper_dq_oe_o),
        .hyper_rwds_i    (hyper_rwds_i),
        .hyper_rwds_o    (hyper_rwds_o),
        .hyper_rwds_oe_o (hyper_rwds_oe_o),
        .busy_o          (busy_o),
        .abort_o         (abort_o)
    );

    int n_chk = 0;
    int n_pass = 0;
    int abort_seen = 0;
    int first_data_edge;
    bit chk_en = 1'b0;

    // Expected outputs, updated by the transaction model.
    logic       e_busy = 0, e_abort = 0, e_dq_oe = 0, e_rwds_oe = 0, e_rwds = 0;
    logic [7:0] e_dq = 0;

    logic [15:0] m_mem [256];
    logic [15:0] m_cr0 = CR0_DEF;
    logic [7:0]  wb [16];
    logic        wm [16];
    logic [7:0]  rb [16];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_o", busy_o, e_busy);
            chk("abort_o", abort_o, e_abort);
            chk("dq_oe", hyper_dq_oe_o, e_dq_oe);
            chk("rwds_oe", hyper_rwds_oe_o, e_rwds_oe);
            if (e_dq_oe) chk("dq_o", hyper_dq_o, e_dq);
            if (e_rwds_oe) chk("rwds_o", hyper_rwds_o, e_rwds);
            if (abort_o) abort_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_busy = 0; e_abort = 0; e_dq_oe = 0; e_rwds_oe = 0; e_rwds = 0;
    endtask

    // One transaction; stop >= 0 cuts it after that many edges, rst_end ends it with rst_ni.
    task automatic xfer(input bit rd, input bit as, input logic [31:0] wa, input int nbytes,
                        input int stop, input bit rst_end);
        logic [47:0] ca;
        logic [31:0] a;
        logic [15:0] w;
        int dstart, nedge, k;
        ca = {rd, as, 1'b0, wa[31:3], 13'b0, wa[2:0]};
        dstart = (!rd && as) ? 6 : 4 * LAT + 2;
        nedge = (stop >= 0) ? stop : dstart + nbytes;
        first_data_edge = -1;
        hyper_cs_ni = 0;
        tick();
        e_busy = 1; e_rwds_oe = 1; e_rwds = 1; e_dq_oe = 0; e_abort = 0;
        for (int e = 0; e < nedge; e++) begin
            hyper_ck_i = ~hyper_ck_i;
            hyper_dq_i = 8'h00;
            hyper_rwds_i = 1'b0;
            if (e < 6) hyper_dq_i = ca[47 - 8 * e -: 8];
            else if (e >= dstart && !rd) begin
                hyper_dq_i = wb[e - dstart];
                hyper_rwds_i = wm[e - dstart];
            end
            tick();
            if (e >= dstart) begin
                k = e - dstart;
                a = wa + 32'(k / 2);
                if (rd) begin
                    w = as ? ((a == 0) ? ID0 : m_cr0) : m_mem[a[7:0]];
                    e_dq = k[0] ? w[7:0] : w[15:8];
                    e_dq_oe = 1;
                    e_rwds = ~k[0];
                    if (k < 16) rb[k] = hyper_dq_o;
                end else if (k[0]) begin
                    if (as) begin
                        if (k == 1) m_cr0 = {wb[0], wb[1]};
                    end else begin
                        if (!wm[k - 1]) m_mem[a[7:0]][15:8] = wb[k - 1];
                        if (!wm[k]) m_mem[a[7:0]][7:0] = wb[k];
                    end
                end
            end
            if (rd && first_data_edge < 0 && hyper_dq_oe_o) first_data_edge = e;
            tick();
            if (e == 5) begin
                if (rd) e_rwds = 0;
                else e_rwds_oe = 0;
            end
        end
        if (rst_end) begin
            rst_ni = 0;
            tick();
            exp_idle();
            m_cr0 = CR0_DEF;
            chk("rst_dq_oe", hyper_dq_oe_o, 1'b0);
            chk("rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
            rst_ni = 1;
            hyper_cs_ni = 1;
            tick();
            tick();
        end else begin
            hyper_cs_ni = 1;
            tick();
            e_abort = (nedge < 6);
            e_busy = 0; e_dq_oe = 0; e_rwds_oe = 0; e_rwds = 0;
            tick();
            e_abort = 0;
            tick();
        end
    endtask

    task automatic set_wr(input logic [63:0] bytes, input logic [7:0] mask);
        for (int i = 0; i < 8; i++) begin
            wb[i] = bytes[63 - 8 * i -: 8];
            wm[i] = mask[7 - i];
        end
    endtask

    initial begin
        logic [63:0] ex;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        tick();
        chk_en = 1;
        chk("reset_outputs", {hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o, busy_o, abort_o}, 0);
        tick();
        rst_ni = 1;
        tick();
        tick();

        // 4-word write then read at 0x10
        set_wr(64'h1111_2222_3333_4444, 8'h00);
        xfer(0, 0, 32'h10, 8, -1, 0);
        xfer(1, 0, 32'h10, 8, -1, 0);
        ex = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 8; i++) chk("rd_0x10_byte", rb[i], ex[63 - 8 * i -: 8]);
        chk("first_data_edge", first_data_edge, 26);

        // masked lower byte over 0000
        set_wr(64'h0000_0000_0000_0000, 8'h00);
        xfer(0, 0, 32'h5, 2, -1, 0);
        set_wr(64'hABCD_0000_0000_0000, 8'b0100_0000);
        xfer(0, 0, 32'h5, 2, -1, 0);
        xfer(1, 0, 32'h5, 2, -1, 0);
        chk("masked_word", {rb[0], rb[1]}, 16'hAB00);

        // address wrap
        set_wr(64'hA0A1_B0B1_C0C1_0000, 8'h00);
        xfer(0, 0, 32'hFF, 6, -1, 0);
        xfer(1, 0, 32'h00, 4, -1, 0);
        chk("wrap_0x00", {rb[0], rb[1]}, 16'hB0B1);
        chk("wrap_0x01", {rb[2], rb[3]}, 16'hC0C1);
        xfer(1, 0, 32'hFF, 2, -1, 0);
        chk("wrap_0xff", {rb[0], rb[1]}, 16'hA0A1);

        // register space
        xfer(1, 1, 32'h0, 2, -1, 0);
        chk("reg_id0", {rb[0], rb[1]}, 16'h0C81);
        set_wr(64'h8F17_1234_0000_0000, 8'h00);
        xfer(0, 1, 32'h800, 4, -1, 0);
        xfer(1, 1, 32'h800, 2, -1, 0);
        chk("reg_cr0_written", {rb[0], rb[1]}, 16'h8F17);
        hyper_reset_ni = 0;
        tick();
        m_cr0 = CR0_DEF;
        hyper_reset_ni = 1;
        tick();
        xfer(1, 1, 32'h800, 2, -1, 0);
        chk("reg_cr0_reset", {rb[0], rb[1]}, 16'h8F1F);

        // aborts
        abort_seen = 0;
        xfer(1, 0, 32'h0, 0, 3, 0);
        chk("abort_pulses", abort_seen, 1);
        set_wr(64'h5555_6666_0000_0000, 8'h00);
        xfer(0, 0, 32'h30, 4, -1, 0);
        set_wr(64'h7788_9900_0000_0000, 8'h00);
        xfer(0, 0, 32'h30, 3, 4 * LAT + 2 + 3, 0);
        xfer(1, 0, 32'h30, 4, -1, 0);
        chk("partial_word0", {rb[0], rb[1]}, 16'h7788);
        chk("partial_word1", {rb[2], rb[3]}, 16'h6666);

        // reset during RDATA, then a fresh transaction
        xfer(1, 0, 32'h10, 8, 4 * LAT + 2 + 3, 1);
        xfer(1, 0, 32'h10, 4, -1, 0);
        chk("post_reset_rd", {rb[0], rb[1], rb[2], rb[3]}, 32'h1111_2222);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
